// File: rtl/seq_divider16_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  // Requester side: issues operands, observes results.
  modport master (
    output start, A, B,
    input  quotient, remainder, busy, done, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, A, B,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// results held from done until the next accepted start.
module seq_divider16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider16_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;       // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs;       // latched divisor
  logic [WIDTH-1:0] prem;      // partial remainder; always < divisor between steps
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   prem_sh;   // partial remainder after the left shift, WIDTH+1 bits
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             last_iter;

  // One restoring step: shift, trial subtract, keep or restore.
  always_comb begin
    prem_sh  = {prem, dvd[WIDTH-1]};
    trial    = prem_sh - {1'b0, dvs};
    prem_nxt = prem_sh[WIDTH-1:0];
    dvd_nxt  = {dvd[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      prem_nxt = trial[WIDTH-1:0];
      dvd_nxt  = {dvd[WIDTH-2:0], 1'b1};
    end
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dvd             <= '0;
      dvs             <= '0;
      prem            <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.B != '0) begin
              dvd             <= bus.A;
              dvs             <= bus.B;
              prem            <= '0;
              cnt             <= '0;
              bus.div_by_zero <= 1'b0;
              state           <= RUN;
            end else begin
              // Divide by zero completes immediately with a saturated quotient.
              bus.quotient    <= '1;
              bus.remainder   <= bus.A;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state           <= DONE;
            end
          end
        end
        RUN: begin
          prem <= prem_nxt;
          dvd  <= dvd_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) begin
            bus.quotient  <= dvd_nxt;
            bus.remainder <= prem_nxt;
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Directed bench for seq_divider16: results, latency, handshake, reset abort.
module tb_seq_divider16;

  localparam int PERIOD = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  time  t_acc;

  seq_divider16_if #(.WIDTH(16)) bus ();

  seq_divider16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #(PERIOD / 2) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge; returns #1 after the accept edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    t_acc = $time;
    #1;
    bus.start = 1'b0;
  endtask

  // Latency in edges from the accept edge to the edge that raised done.
  task automatic wait_done(output int lat);
    int guard;
    guard = 0;
    while (!bus.done && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    lat = int'(($time - 1 - t_acc) / PERIOD);
  endtask

  task automatic finish_op(input string tag, input logic [15:0] eq, input logic [15:0] er,
                           input logic edz, input int elat);
    int lat;
    wait_done(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_q"}, 32'(bus.quotient), 32'(eq));
    check_eq({tag, "_r"}, 32'(bus.remainder), 32'(er));
    check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edz));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          seen_done;

    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_q", 32'(bus.quotient), 32'd0);
    check_eq("rst_r", 32'(bus.remainder), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic divide with handshake timing.
    launch(16'd100, 16'd7);
    check_eq("d100_busy", 32'(bus.busy), 32'd1);
    check_eq("d100_done_early", 32'(bus.done), 32'd0);
    finish_op("d100", 16'd14, 16'd2, 1'b0, 16);

    // Width boundaries.
    launch(16'hFFFF, 16'd1);
    finish_op("ffff_1", 16'hFFFF, 16'd0, 1'b0, 16);
    launch(16'h8000, 16'h8000);
    finish_op("8000_8000", 16'd1, 16'd0, 1'b0, 16);
    launch(16'hFFFF, 16'hFFFF);
    finish_op("ffff_ffff", 16'd1, 16'd0, 1'b0, 16);

    // A < B, divide by zero, then a valid divide clears the flag (A=0 case).
    launch(16'd3, 16'd10);
    finish_op("d3_10", 16'd0, 16'd3, 1'b0, 16);
    launch(16'd5, 16'd0);
    finish_op("dbz", 16'hFFFF, 16'd5, 1'b1, 0);
    launch(16'd0, 16'd7);
    finish_op("zero_7", 16'd0, 16'd0, 1'b0, 16);

    // Start and operand changes during RUN are ignored; outputs held until exit.
    launch(16'd1000, 16'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 16'd9;
      bus.B     = 16'd9;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = 16'(16'hA5A5 + i);
      bus.B     = 16'd0;
    end
    check_eq("mid_q_held", 32'(bus.quotient), 32'd0);
    check_eq("mid_busy", 32'(bus.busy), 32'd1);
    finish_op("d1000", 16'd333, 16'd1, 1'b0, 16);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_q", 32'(bus.quotient), 32'd333);
    check_eq("hold_r", 32'(bus.remainder), 32'd1);
    check_eq("hold_done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-operation aborts without a done pulse.
    launch(16'd500, 16'd4);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_q", 32'(bus.quotient), 32'd0);
    check_eq("arst_r", 32'(bus.remainder), 32'd0);
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_done", 32'(bus.done), 32'd0);
    check_eq("arst_dbz", 32'(bus.div_by_zero), 32'd0);
    seen_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done = 1;
    end
    check_eq("arst_no_done", 32'(seen_done), 32'd0);
    launch(16'd500, 16'd4);
    finish_op("d500", 16'd125, 16'd0, 1'b0, 16);

    // Short sweep against the arithmetic reference.
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom);
      if (rb == 16'd0) rb = 16'd1;
      launch(ra, rb);
      finish_op("sweep", ra / rb, ra % rb, 1'b0, 16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
